// File: rtl/nonce_frame_rx.sv
// Hash-input frame receiver. Pops a tag word and DATA_WORDS header words from
// the hashin FIFO, then checks the nonce embedded in the last header word
// against the nonce FIFO. A matching block is offered to the hash core over
// valid/ready.
module nonce_frame_rx #(
  parameter logic [63:0] FRAME_TAG  = 64'h8000000000000280,
  parameter int unsigned DATA_WORDS = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [63:0]                hashin_fifo_dout,
  input  logic                       hashin_fifo_empty,
  output logic                       hashin_fifo_re,
  input  logic [31:0]                nonce_fifo_dout,
  input  logic                       nonce_fifo_empty,
  output logic                       nonce_fifo_re,
  input  logic                       flush,
  output logic                       blk_valid,
  input  logic                       blk_ready,
  output logic [64*DATA_WORDS-1:0]   blk_data,
  output logic [31:0]                blk_nonce,
  output logic [31:0]                frame_cnt,
  output logic [15:0]                err_tag_cnt,
  output logic [15:0]                err_nonce_cnt,
  output logic                       idle
);

  localparam int unsigned BlkW = 64 * DATA_WORDS;
  localparam int unsigned CntW = $clog2(DATA_WORDS + 1);
  localparam logic [CntW-1:0] LastWord = CntW'(DATA_WORDS - 1);

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_NONCE   = 2'd2;
  localparam logic [1:0] ST_OUT     = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [BlkW-1:0] data_q, data_d;
  logic [31:0]     nonce_q, nonce_d;
  logic [31:0]     frame_q, frame_d;
  logic [15:0]     err_tag_q, err_tag_d;
  logic [15:0]     err_nonce_q, err_nonce_d;
  logic [31:0]     hdr_nonce;

  // Header carries the nonce little-endian in its final 32 bits.
  assign hdr_nonce = {data_q[7:0], data_q[15:8], data_q[23:16], data_q[31:24]};

  // Next-state, FIFO pops and handshake; flush overrides every state action.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    data_d         = data_q;
    nonce_d        = nonce_q;
    frame_d        = frame_q;
    err_tag_d      = err_tag_q;
    err_nonce_d    = err_nonce_q;
    hashin_fifo_re = 1'b0;
    nonce_fifo_re  = 1'b0;
    blk_valid      = 1'b0;
    if (flush) begin
      state_d = ST_HUNT;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (!hashin_fifo_empty) begin
            hashin_fifo_re = 1'b1;
            if (hashin_fifo_dout == FRAME_TAG) begin
              state_d = ST_COLLECT;
              cnt_d   = '0;
            end else if (err_tag_q != 16'hFFFF) begin
              err_tag_d = err_tag_q + 16'd1;
            end
          end
        end
        ST_COLLECT: begin
          if (!hashin_fifo_empty) begin
            hashin_fifo_re = 1'b1;
            data_d         = {data_q[BlkW-65:0], hashin_fifo_dout};
            if (cnt_q == LastWord) begin
              state_d = ST_NONCE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_NONCE: begin
          if (!nonce_fifo_empty) begin
            nonce_fifo_re = 1'b1;
            if (nonce_fifo_dout == hdr_nonce) begin
              nonce_d = nonce_fifo_dout;
              state_d = ST_OUT;
            end else begin
              if (err_nonce_q != 16'hFFFF) begin
                err_nonce_d = err_nonce_q + 16'd1;
              end
              state_d = ST_HUNT;
            end
          end
        end
        ST_OUT: begin
          blk_valid = 1'b1;
          if (blk_ready) begin
            frame_d = frame_q + 32'd1;
            state_d = ST_HUNT;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      cnt_q       <= '0;
      data_q      <= '0;
      nonce_q     <= '0;
      frame_q     <= '0;
      err_tag_q   <= '0;
      err_nonce_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      nonce_q     <= nonce_d;
      frame_q     <= frame_d;
      err_tag_q   <= err_tag_d;
      err_nonce_q <= err_nonce_d;
    end
  end

  assign blk_data      = data_q;
  assign blk_nonce     = nonce_q;
  assign frame_cnt     = frame_q;
  assign err_tag_cnt   = err_tag_q;
  assign err_nonce_cnt = err_nonce_q;
  assign idle          = (state_q == ST_HUNT);

endmodule

// File: tb/tb_nonce_frame_rx.sv
// Directed bench for nonce_frame_rx with FWFT FIFO models for both inputs.
module tb_nonce_frame_rx;

  localparam logic [63:0] TAG     = 64'h8000000000000280;
  localparam logic [63:0] GARBAGE = 64'hDEADBEEF00000000;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  hashin_fifo_dout;
  logic         hashin_fifo_empty;
  logic         hashin_fifo_re;
  logic [31:0]  nonce_fifo_dout;
  logic         nonce_fifo_empty;
  logic         nonce_fifo_re;
  logic         flush;
  logic         blk_valid;
  logic         blk_ready;
  logic [639:0] blk_data;
  logic [31:0]  blk_nonce;
  logic [31:0]  frame_cnt;
  logic [15:0]  err_tag_cnt;
  logic [15:0]  err_nonce_cnt;
  logic         idle;

  int errors = 0;
  int checks = 0;

  // FIFO models
  logic [63:0] hmem [0:255];
  logic [31:0] nmem [0:255];
  int hhead = 0, htail = 0, nhead = 0, ntail = 0;
  int hpops = 0, npops = 0, viol = 0, vcount = 0, cyc = 0;
  bit garbage_mode = 1'b0, gap_mode = 1'b0;
  logic gap = 1'b0;
  logic [7:0] hidx, nidx;

  // Handshake log
  int           hs_n = 0;
  int           hs_cyc   [0:31];
  logic [31:0]  hs_nonce [0:31];
  logic [639:0] hs_data  [0:31];

  always #5 clk = ~clk;

  assign hidx              = hhead[7:0];
  assign nidx              = nhead[7:0];
  assign hashin_fifo_dout  = garbage_mode ? GARBAGE : hmem[hidx];
  assign hashin_fifo_empty = garbage_mode ? 1'b0 : ((hhead == htail) || gap);
  assign nonce_fifo_dout   = nmem[nidx];
  assign nonce_fifo_empty  = (nhead == ntail);

  nonce_frame_rx dut (
    .clk               (clk),
    .rst               (rst),
    .hashin_fifo_dout  (hashin_fifo_dout),
    .hashin_fifo_empty (hashin_fifo_empty),
    .hashin_fifo_re    (hashin_fifo_re),
    .nonce_fifo_dout   (nonce_fifo_dout),
    .nonce_fifo_empty  (nonce_fifo_empty),
    .nonce_fifo_re     (nonce_fifo_re),
    .flush             (flush),
    .blk_valid         (blk_valid),
    .blk_ready         (blk_ready),
    .blk_data          (blk_data),
    .blk_nonce         (blk_nonce),
    .frame_cnt         (frame_cnt),
    .err_tag_cnt       (err_tag_cnt),
    .err_nonce_cnt     (err_nonce_cnt),
    .idle              (idle)
  );

  // FIFO pops, pop-while-empty detection and handshake logging.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    gap <= gap_mode ? ~gap : 1'b0;
    viol <= viol + ((hashin_fifo_re && hashin_fifo_empty) ? 1 : 0)
                 + ((nonce_fifo_re && nonce_fifo_empty) ? 1 : 0);
    if (hashin_fifo_re) begin
      hpops <= hpops + 1;
      if (!garbage_mode) hhead <= hhead + 1;
    end
    if (nonce_fifo_re) begin
      npops <= npops + 1;
      nhead <= nhead + 1;
    end
    if (blk_valid) vcount <= vcount + 1;
    if (blk_valid && blk_ready && !rst && !flush) begin
      hs_cyc[hs_n]   <= cyc;
      hs_nonce[hs_n] <= blk_nonce;
      hs_data[hs_n]  <= blk_data;
      hs_n           <= hs_n + 1;
    end
  end

  function automatic logic [63:0] data_word(input int seed, input int i,
                                            input logic [31:0] hn);
    if (i == 9) return {32'h9ABCDEF0 + seed[31:0], hn[7:0], hn[15:8], hn[23:16], hn[31:24]};
    return 64'h0001020304050607 + 64'(i) * 64'h0808080808080808
         + 64'(seed) * 64'h0100000000000000;
  endfunction

  task automatic push_h(input logic [63:0] w);
    hmem[htail[7:0]] = w;
    htail = htail + 1;
  endtask

  task automatic push_n(input logic [31:0] n);
    nmem[ntail[7:0]] = n;
    ntail = ntail + 1;
  endtask

  task automatic push_frame(input int seed, input logic [31:0] hdr_nonce,
                            input logic [31:0] fifo_nonce, output logic [639:0] exp_d);
    logic [63:0] w;
    exp_d = '0;
    push_h(TAG);
    for (int i = 0; i < 10; i++) begin
      w = data_word(seed, i, hdr_nonce);
      push_h(w);
      exp_d = {exp_d[575:0], w};
    end
    push_n(fifo_nonce);
  endtask

  // Returns the number of falling edges until blk_valid, or -1 on timeout.
  task automatic wait_valid(input int max, output int n);
    n = -1;
    for (int k = 1; k <= max; k++) begin
      @(negedge clk);
      #1;
      if (blk_valid) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; blk_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", blk_valid); end
    checks++; if (blk_data !== 640'd0) begin errors++; $display("FAIL reset_data got %h want 0", blk_data); end
    checks++; if (blk_nonce !== 32'd0) begin errors++; $display("FAIL reset_nonce got %h want 0", blk_nonce); end
    checks++; if ({frame_cnt, err_tag_cnt, err_nonce_cnt} !== 64'd0) begin
      errors++; $display("FAIL reset_counters got %h/%h/%h want 0", frame_cnt, err_tag_cnt, err_nonce_cnt);
    end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", idle); end
    checks++; if ({hashin_fifo_re, nonce_fifo_re} !== 2'b00) begin
      errors++; $display("FAIL reset_re got %b%b want 00", hashin_fifo_re, nonce_fifo_re);
    end
  endtask

  task automatic test_single;
    logic [639:0] exp_d;
    int n;
    blk_ready = 1'b1;
    push_frame(0, 32'h12345678, 32'h12345678, exp_d);
    wait_valid(40, n);
    checks++; if (n != 12) begin errors++; $display("FAIL single_latency got %0d want 12", n); end
    checks++; if (blk_data[639:576] !== 64'h0001020304050607) begin
      errors++; $display("FAIL single_first_word got %h want 0001020304050607", blk_data[639:576]);
    end
    checks++; if (blk_data !== exp_d) begin errors++; $display("FAIL single_data got %h want %h", blk_data, exp_d); end
    checks++; if (blk_nonce !== 32'h12345678) begin errors++; $display("FAIL single_nonce got %h want 12345678", blk_nonce); end
    @(negedge clk); #1;
    checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop got %b want 0", blk_valid); end
    checks++; if (frame_cnt !== 32'd1) begin errors++; $display("FAIL single_frame_cnt got %0d want 1", frame_cnt); end
    checks++; if ({err_tag_cnt, err_nonce_cnt} !== 32'd0) begin
      errors++; $display("FAIL single_err_cnt got %h/%h want 0/0", err_tag_cnt, err_nonce_cnt);
    end
  endtask

  task automatic test_garbage;
    logic [639:0] exp_d;
    int n;
    repeat (3) push_h(GARBAGE);
    push_frame(1, 32'hA1B2C3D4, 32'hA1B2C3D4, exp_d);
    wait_valid(60, n);
    checks++; if (n != 15) begin errors++; $display("FAIL garbage_latency got %0d want 15", n); end
    checks++; if (err_tag_cnt !== 16'd3) begin errors++; $display("FAIL garbage_err_tag got %0d want 3", err_tag_cnt); end
    checks++; if (blk_data !== exp_d) begin errors++; $display("FAIL garbage_data got %h want %h", blk_data, exp_d); end
    checks++; if (blk_nonce !== 32'hA1B2C3D4) begin errors++; $display("FAIL garbage_nonce got %h want a1b2c3d4", blk_nonce); end
    @(negedge clk);
  endtask

  task automatic test_mismatch;
    logic [639:0] exp_d;
    int n, v0;
    v0 = vcount;
    push_frame(2, 32'h12345678, 32'h12345679, exp_d);
    repeat (16) @(negedge clk);
    #1;
    checks++; if (vcount != v0) begin errors++; $display("FAIL mismatch_no_valid got %0d want 0", vcount - v0); end
    checks++; if (err_nonce_cnt !== 16'd1) begin errors++; $display("FAIL mismatch_err_nonce got %0d want 1", err_nonce_cnt); end
    checks++; if (idle !== 1'b1 || nhead != ntail) begin
      errors++; $display("FAIL mismatch_hunt got idle=%b nonce_left=%0d want 1/0", idle, ntail - nhead);
    end
    push_frame(3, 32'h0BADF00D, 32'h0BADF00D, exp_d);
    wait_valid(40, n);
    checks++; if (n != 12 || blk_data !== exp_d) begin
      errors++; $display("FAIL mismatch_next got n=%0d data=%h want 12/%h", n, blk_data, exp_d);
    end
    @(negedge clk);
  endtask

  task automatic test_gaps;
    logic [639:0] exp_d;
    int n, v0;
    v0 = viol;
    gap_mode = 1'b1;
    push_frame(4, 32'hCAFEBABE, 32'hCAFEBABE, exp_d);
    wait_valid(80, n);
    gap_mode = 1'b0;
    checks++; if (n < 0 || blk_data !== exp_d) begin
      errors++; $display("FAIL gaps_data got n=%0d data=%h want %h", n, blk_data, exp_d);
    end
    checks++; if (viol != v0) begin errors++; $display("FAIL gaps_re_while_empty got %0d want 0", viol - v0); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [639:0] exp1, exp2;
    int n, hp, np;
    bit stable;
    blk_ready = 1'b0;
    push_frame(5, 32'h55AA55AA, 32'h55AA55AA, exp1);
    push_frame(6, 32'h66776677, 32'h66776677, exp2);
    wait_valid(40, n);
    checks++; if (n != 12) begin errors++; $display("FAIL bp_latency got %0d want 12", n); end
    hp = hpops; np = npops; stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (!blk_valid || blk_data !== exp1 || blk_nonce !== 32'h55AA55AA) stable = 1'b0;
    end
    checks++; if (!stable) begin errors++; $display("FAIL bp_stable got unstable want stable"); end
    checks++; if (hpops != hp || npops != np) begin
      errors++; $display("FAIL bp_no_pops got %0d/%0d want 0/0", hpops - hp, npops - np);
    end
    blk_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (blk_valid !== 1'b0 || hashin_fifo_re !== 1'b1) begin
      errors++; $display("FAIL bp_resume got valid=%b re=%b want 0/1", blk_valid, hashin_fifo_re);
    end
    wait_valid(40, n);
    checks++; if (n != 12 || blk_data !== exp2) begin
      errors++; $display("FAIL bp_second got n=%0d data=%h want 12/%h", n, blk_data, exp2);
    end
    @(negedge clk);
  endtask

  task automatic test_flush;
    logic [639:0] exp_d;
    int n, hp, e0, v0;
    hp = hpops;
    push_h(TAG);
    for (int i = 0; i < 4; i++) push_h(data_word(7, i, 32'h0));
    for (int k = 0; k < 20 && hpops < hp + 5; k++) @(negedge clk);
    #1;
    checks++; if (hpops != hp + 5 || idle !== 1'b0) begin
      errors++; $display("FAIL flush_collect got pops=%0d idle=%b want 5/0", hpops - hp, idle);
    end
    e0 = err_tag_cnt; v0 = vcount;
    flush = 1'b1;
    for (int i = 4; i < 10; i++) push_h(data_word(7, i, 32'h0));
    #1;
    checks++; if (hashin_fifo_re !== 1'b0) begin errors++; $display("FAIL flush_no_pop got %b want 0", hashin_fifo_re); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++; if (idle !== 1'b1 || blk_valid !== 1'b0) begin
      errors++; $display("FAIL flush_hunt got idle=%b valid=%b want 1/0", idle, blk_valid);
    end
    repeat (8) @(negedge clk);
    #1;
    checks++; if (err_tag_cnt !== 16'(e0 + 6)) begin
      errors++; $display("FAIL flush_err_tag got %0d want %0d", err_tag_cnt, e0 + 6);
    end
    checks++; if (vcount != v0) begin errors++; $display("FAIL flush_no_valid got %0d want 0", vcount - v0); end
    push_frame(8, 32'h88888888, 32'h88888888, exp_d);
    wait_valid(40, n);
    checks++; if (n != 12 || blk_data !== exp_d) begin
      errors++; $display("FAIL flush_next got n=%0d data=%h want 12/%h", n, blk_data, exp_d);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [639:0] e0, e1, e2;
    int h0;
    logic [31:0] f0;
    blk_ready = 1'b1;
    h0 = hs_n; f0 = frame_cnt;
    push_frame(10, 32'd0, 32'd0, e0);
    push_frame(11, 32'd1, 32'd1, e1);
    push_frame(12, 32'd2, 32'd2, e2);
    repeat (50) @(negedge clk);
    #1;
    checks++; if (hs_n != h0 + 3) begin errors++; $display("FAIL b2b_count got %0d want 3", hs_n - h0); end
    checks++; if (frame_cnt !== f0 + 32'd3) begin errors++; $display("FAIL b2b_frame_cnt got %0d want %0d", frame_cnt, f0 + 3); end
    if (hs_n == h0 + 3) begin
      checks++; if (hs_cyc[h0+1] - hs_cyc[h0] != 13 || hs_cyc[h0+2] - hs_cyc[h0+1] != 13) begin
        errors++; $display("FAIL b2b_spacing got %0d/%0d want 13/13",
                           hs_cyc[h0+1] - hs_cyc[h0], hs_cyc[h0+2] - hs_cyc[h0+1]);
      end
      checks++; if (hs_nonce[h0] !== 32'd0 || hs_nonce[h0+1] !== 32'd1 || hs_nonce[h0+2] !== 32'd2) begin
        errors++; $display("FAIL b2b_nonces got %0d/%0d/%0d want 0/1/2",
                           hs_nonce[h0], hs_nonce[h0+1], hs_nonce[h0+2]);
      end
      checks++; if (hs_data[h0] !== e0 || hs_data[h0+1] !== e1 || hs_data[h0+2] !== e2) begin
        errors++; $display("FAIL b2b_data got %h want %h", hs_data[h0+2], e2);
      end
    end
  endtask

  task automatic test_saturation;
    logic [31:0] f0;
    f0 = frame_cnt;
    garbage_mode = 1'b1;
    repeat (70000) @(negedge clk);
    garbage_mode = 1'b0;
    #1;
    @(negedge clk); #1;
    checks++; if (err_tag_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_err_tag got %h want ffff", err_tag_cnt); end
    checks++; if (idle !== 1'b1 || frame_cnt !== f0) begin
      errors++; $display("FAIL sat_state got idle=%b frames=%0d want 1/%0d", idle, frame_cnt, f0);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; blk_ready = 1'b0;
    test_reset;
    test_single;
    test_garbage;
    test_mismatch;
    test_gaps;
    test_backpressure;
    test_flush;
    test_back_to_back;
    test_saturation;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
